// File: rtl/sig_gen_pkg.sv
// rtl/sig_gen_pkg.sv - shared mode/state types for the phase counter datapath
package sig_gen_pkg;

    typedef enum logic [1:0] {
        MODE_FREE     = 2'd0,
        MODE_PINGPONG = 2'd1,
        MODE_ONESHOT  = 2'd2
    } mode_t;

    typedef enum logic [1:0] {
        ST_UP,
        ST_DOWN,
        ST_HALT
    } state_t;

    localparam logic [1:0] MODE_RESERVED = 2'b11;

endpackage

// File: rtl/sig_phase_counter_if.sv
// rtl/sig_phase_counter_if.sv - control/status bundle of the phase counter (SIG_PHASE_OFFSET_EN adds offset/count_b)
interface sig_phase_counter_if #(
    parameter int WIDTH = 8
);
    logic             en;
    logic [WIDTH-1:0] incr;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic [1:0]       mode;
    logic [WIDTH-1:0] count;
    logic             wrap;
    logic             dir;
    logic             done;
`ifdef SIG_PHASE_OFFSET_EN
    logic [WIDTH-1:0] offset;
    logic [WIDTH-1:0] count_b;

    modport master (
        output en, incr, load, load_val, mode, offset,
        input  count, wrap, dir, done, count_b
    );
    modport slave (
        input  en, incr, load, load_val, mode, offset,
        output count, wrap, dir, done, count_b
    );
`else
    modport master (
        output en, incr, load, load_val, mode,
        input  count, wrap, dir, done
    );
    modport slave (
        input  en, incr, load, load_val, mode,
        output count, wrap, dir, done
    );
`endif
endinterface

// File: rtl/sig_mod_add.sv
// rtl/sig_mod_add.sv - combinational (a+b) mod LIMIT with wrap flag, for a,b < LIMIT
module sig_mod_add #(
    parameter int WIDTH = 8,
    parameter int LIMIT = 256
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y,
    output logic             wrap
);
    localparam logic [WIDTH:0] LIM = (WIDTH+1)'(LIMIT);

    logic [WIDTH:0] sum;
    logic [WIDTH:0] red;

    always_comb begin
        sum  = {1'b0, a} + {1'b0, b};
        red  = sum - LIM;
        wrap = (sum >= LIM);
        y    = wrap ? red[WIDTH-1:0] : sum[WIDTH-1:0];
    end

endmodule

// File: rtl/sig_phase_counter.sv
// rtl/sig_phase_counter.sv - phase/address generator: free wrap, ping-pong and one-shot modes
// Optional second channel output count_b enabled by SIG_PHASE_OFFSET_EN.
module sig_phase_counter
    import sig_gen_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int LIMIT = 256
) (
    input  logic                clk,
    input  logic                rst,
    sig_phase_counter_if.slave  bus
);
    localparam logic [WIDTH-1:0] LIM_M1 = WIDTH'(LIMIT - 1);

    mode_t            mode_q, n_mode;
    state_t           state, n_state;
    logic [WIDTH-1:0] count, n_count;
    logic             wrap, n_wrap;
    logic             dir, n_dir;
    logic             done, n_done;

    logic [WIDTH-1:0] step;
    logic [WIDTH:0]   up_sum;
    logic             reach_top;
    logic [WIDTH-1:0] add_y;
    logic             add_wrap;

    assign step      = (bus.incr > LIM_M1) ? LIM_M1 : bus.incr;
    assign up_sum    = {1'b0, count} + {1'b0, step};
    assign reach_top = (up_sum >= {1'b0, LIM_M1});

    sig_mod_add #(.WIDTH(WIDTH), .LIMIT(LIMIT)) u_add_main (
        .a    (count),
        .b    (step),
        .y    (add_y),
        .wrap (add_wrap)
    );

    always_comb begin
        n_count = count;
        n_state = state;
        n_mode  = mode_q;
        n_dir   = dir;
        n_done  = done;
        n_wrap  = 1'b0;
        if (rst) begin
            n_count = '0;
            n_state = ST_UP;
            n_mode  = MODE_FREE;
            n_dir   = 1'b1;
            n_done  = 1'b0;
        end else if (bus.load) begin
            n_count = (bus.load_val > LIM_M1) ? LIM_M1 : bus.load_val;
            n_mode  = (bus.mode == MODE_RESERVED) ? MODE_FREE : mode_t'(bus.mode);
            n_state = ST_UP;
            n_dir   = 1'b1;
            n_done  = 1'b0;
        end else if (bus.en && step != '0) begin
            // A zero step is a pure hold: it must not trip the end-of-range tests below.
            case (mode_q)
                MODE_FREE: begin
                    n_count = add_y;
                    n_wrap  = add_wrap;
                end
                MODE_PINGPONG: begin
                    if (state == ST_DOWN) begin
                        if (count <= step) begin
                            n_count = '0;
                            n_state = ST_UP;
                            n_dir   = 1'b1;
                            n_wrap  = 1'b1;
                        end else begin
                            n_count = count - step;
                        end
                    end else if (reach_top) begin
                        n_count = LIM_M1;
                        n_state = ST_DOWN;
                        n_dir   = 1'b0;
                        n_wrap  = 1'b1;
                    end else begin
                        n_count = add_y;
                    end
                end
                MODE_ONESHOT: begin
                    if (state == ST_UP) begin
                        if (reach_top) begin
                            n_count = LIM_M1;
                            n_state = ST_HALT;
                            n_done  = 1'b1;
                            n_wrap  = 1'b1;
                        end else begin
                            n_count = add_y;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        count  <= n_count;
        state  <= n_state;
        mode_q <= n_mode;
        dir    <= n_dir;
        done   <= n_done;
        wrap   <= n_wrap;
    end

    assign bus.count = count;
    assign bus.wrap  = wrap;
    assign bus.dir   = dir;
    assign bus.done  = done;

`ifdef SIG_PHASE_OFFSET_EN
    logic [WIDTH-1:0] off_c;
    logic [WIDTH-1:0] b_sum;
    logic             b_wrap_unused;
    logic [WIDTH-1:0] count_b;

    assign off_c = (bus.offset > LIM_M1) ? LIM_M1 : bus.offset;

    // Built from the next count so the second channel lands on the same edge as count.
    sig_mod_add #(.WIDTH(WIDTH), .LIMIT(LIMIT)) u_add_b (
        .a    (n_count),
        .b    (off_c),
        .y    (b_sum),
        .wrap (b_wrap_unused)
    );

    always_ff @(posedge clk) begin
        count_b <= b_sum;
    end

    assign bus.count_b = count_b;
`endif

endmodule

// File: tb/tb_sig_phase_counter.sv
// tb/tb_sig_phase_counter.sv - directed checks of sig_phase_counter at WIDTH=8, LIMIT=200
module tb_sig_phase_counter;

    logic clk = 1'b0;
    logic rst;
    int   vectors = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    sig_phase_counter_if #(.WIDTH(8)) bus ();

    sig_phase_counter #(.WIDTH(8), .LIMIT(200)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_all(input string tag, input int c, input int w, input int d, input int dn);
        check({tag, ".count"}, 32'(bus.count), 32'(c));
        check({tag, ".wrap"},  32'(bus.wrap),  32'(w));
        check({tag, ".dir"},   32'(bus.dir),   32'(d));
        check({tag, ".done"},  32'(bus.done),  32'(dn));
    endtask

    task automatic do_load(input int v, input int m);
        bus.load = 1'b1; bus.load_val = 8'(v); bus.mode = 2'(m);
        step();
        bus.load = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        bus.en = 1'b0; bus.incr = '0; bus.load = 1'b0; bus.load_val = '0; bus.mode = '0;
`ifdef SIG_PHASE_OFFSET_EN
        bus.offset = 8'd50;
`endif
        step(); expect_all("rst1", 0, 0, 1, 0);
        step(); expect_all("rst2", 0, 0, 1, 0);
        rst = 1'b0; bus.en = 1'b1; bus.incr = 8'd0;
        for (int i = 0; i < 3; i++) begin
            step(); expect_all("incr0", 0, 0, 1, 0);
        end

        // FREE; load is applied with en high and incr=7 to show load wins
        bus.incr = 8'd7;
        do_load(190, 0);    expect_all("free.load_wins", 190, 0, 1, 0);
        step();             expect_all("free.197", 197, 0, 1, 0);
        step();             expect_all("free.4", 4, 1, 1, 0);
        step();             expect_all("free.11", 11, 0, 1, 0);

        // PINGPONG
        do_load(195, 1);    expect_all("pp.load", 195, 0, 1, 0);
        bus.incr = 8'd3;
        step();             expect_all("pp.198", 198, 0, 1, 0);
        step();             expect_all("pp.199", 199, 1, 0, 0);
        step();             expect_all("pp.196", 196, 0, 0, 0);
        step();             expect_all("pp.193", 193, 0, 0, 0);
        bus.incr = 8'd191;
        step();             expect_all("pp.2", 2, 0, 0, 0);
        bus.incr = 8'd3;
        step();             expect_all("pp.0", 0, 1, 1, 0);
        step();             expect_all("pp.3", 3, 0, 1, 0);

        // ONESHOT
        bus.incr = 8'd100;
        do_load(0, 2);      expect_all("os.load", 0, 0, 1, 0);
        step();             expect_all("os.100", 100, 0, 1, 0);
        step();             expect_all("os.199", 199, 1, 1, 1);
        step();             expect_all("os.halt1", 199, 0, 1, 1);
        step();             expect_all("os.halt2", 199, 0, 1, 1);
        do_load(5, 2);      expect_all("os.reload", 5, 0, 1, 0);

        // Load clamp and step clamp
        bus.en = 1'b0;
        do_load(250, 0);    expect_all("clamp.load", 199, 0, 1, 0);
        do_load(0, 0);      expect_all("clamp.zero", 0, 0, 1, 0);
        bus.en = 1'b1; bus.incr = 8'd255;
        step();             expect_all("clamp.199", 199, 0, 1, 0);
        step();             expect_all("clamp.198", 198, 1, 1, 0);

        // Reserved mode behaves as FREE
        bus.incr = 8'd195;
        do_load(10, 3);     expect_all("rsv.load", 10, 0, 1, 0);
        step();             expect_all("rsv.5", 5, 1, 1, 0);

        // en=0 holds
        bus.en = 1'b0; bus.incr = 8'd5;
        do_load(50, 0);     expect_all("hold.load", 50, 0, 1, 0);
        step();             expect_all("hold.50", 50, 0, 1, 0);

        // rst while ping-pong counts down
        bus.en = 1'b1; bus.incr = 8'd10;
        do_load(195, 1);    expect_all("rstpp.load", 195, 0, 1, 0);
        step();             expect_all("rstpp.199", 199, 1, 0, 0);
        step();             expect_all("rstpp.189", 189, 0, 0, 0);
        rst = 1'b1;
        step();             expect_all("rstpp.rst", 0, 0, 1, 0);
        rst = 1'b0;
        step();             expect_all("rstpp.10", 10, 0, 1, 0);

`ifdef SIG_PHASE_OFFSET_EN
        bus.en = 1'b0; rst = 1'b1;
        step();
        check("ofs.rst.count_b", 32'(bus.count_b), 32'd50);
        rst = 1'b0;
        do_load(0, 0);
        check("ofs.load.count_b", 32'(bus.count_b), 32'd50);
        bus.en = 1'b1; bus.incr = 8'd10;
        for (int k = 1; k <= 16; k++) begin
            step();
            check("ofs.count",   32'(bus.count),   32'((10 * k) % 200));
            check("ofs.count_b", 32'(bus.count_b), 32'((10 * k + 50) % 200));
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
